addr_sub_checker: RTL and testbench
===================================

ADDR_SUB_CHECKER -- requirements
Module: addr_sub_checker

Interface
REQ-001 Parameter WIDTH, default 4, operand and sum width in bits.
REQ-002 Parameter NUM_VEC, default 17, vectors checked per run; legal range 1 to 255.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 Port start, input, 1, single-cycle pulse that begins a run.
REQ-006 Port vld_in, input, 1, the vector on a/b/cin/sum/carry is valid this cycle.
REQ-007 Port a, input, WIDTH, operand A applied to the adder/subtractor under test.
REQ-008 Port b, input, WIDTH, operand B applied to the adder/subtractor under test.
REQ-009 Port cin, input, 1, mode: 0 selects add, 1 selects subtract.
REQ-010 Port sum, input, WIDTH, result observed from the unit under test.
REQ-011 Port carry, input, 1, carry-out observed from the unit under test.
REQ-012 Port rdy, output, 1, checker accepts a vector this cycle.
REQ-013 Port busy, output, 1, run in progress.
REQ-014 Port done, output, 1, run complete; results stable.
REQ-015 Port pass_cnt, output, 8, count of matching vectors.
REQ-016 Port fail_cnt, output, 8, count of mismatching vectors.
REQ-017 Port err, output, 1, sticky flag, set on any mismatch in the current run.
REQ-018 Port ff_idx, output, 8, index (0-based) of the first failing vector.
REQ-019 Port ff_vec, output, 2*WIDTH+1, {a,b,cin} of the first failing vector.

Function
REQ-020 The FSM SHALL have states IDLE, RUN and DONE; busy=1 only in RUN, done=1 only in DONE, rdy=1 only in RUN while the accepted count < NUM_VEC.
REQ-021 In IDLE or DONE, start=1 SHALL clear pass_cnt, fail_cnt, err, ff_idx, ff_vec and the accepted count, and move to RUN.
REQ-022 start SHALL be ignored in RUN.
REQ-023 vld_in SHALL be ignored whenever rdy=0.
REQ-024 A vector SHALL be accepted on an edge where vld_in=1 and rdy=1, and SHALL be registered together with its index at that edge.
REQ-025 Expected value for cin=0 SHALL be {carry,sum} = a + b, computed at WIDTH+1 bits.
REQ-026 Expected value for cin=1 SHALL be {carry,sum} = a + ~b + 1, computed at WIDTH+1 bits; carry=1 means no borrow.
REQ-027 The compare of the registered vector SHALL update pass_cnt or fail_cnt at the edge after acceptance (latency 1).
REQ-028 Any X or Z on sum or carry SHALL count as a mismatch.
REQ-029 On the first mismatch of a run, err SHALL be set, and ff_idx and ff_vec SHALL be captured; later mismatches SHALL NOT overwrite them.
REQ-030 pass_cnt and fail_cnt SHALL saturate at 255.
REQ-031 Back-to-back vectors, one per cycle, SHALL be supported with no lost compares.
REQ-032 After the NUM_VEC-th compare updates the counters, the FSM SHALL enter DONE on the same edge.
REQ-033 Once in DONE, all result outputs SHALL hold until start or reset.
REQ-034 The invariant pass_cnt + fail_cnt = NUM_VEC SHALL hold in DONE.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE and all outputs and internal registers to 0, including mid-run; the pipeline register SHALL be discarded.
REQ-036 After rst_n deasserts, the checker SHALL remain in IDLE until start=1.

Verification
REQ-037 Add pass: a=0011, b=0101, cin=0, sum=1000, carry=0 -> pass_cnt +1 one cycle after acceptance, err=0.
REQ-038 Subtract cases: a=0101, b=0011, cin=1, sum=0010, carry=1 -> pass; a=0011, b=0101, cin=1, sum=1110, carry=0 -> pass.
REQ-039 Error injection: 17 back-to-back vectors, vector 4 with carry flipped, vector 9 with sum flipped -> in DONE pass_cnt=15, fail_cnt=2, err=1, ff_idx=4, ff_vec = vector 4's {a,b,cin}.
REQ-040 Handshake: vld_in asserted in IDLE, plus start pulsed mid-RUN -> both ignored; no count change; run completes normally.
REQ-041 Reset mid-run: rst_n=0 after 6 vectors -> all outputs 0 asynchronously; new start then gives a full, clean 17-vector run.
REQ-042 Boundary: a=1111, b=1111, cin=0, expected sum=1110, carry=1; repeated start from DONE clears all counters.

Source files
------------

// File: rtl/addr_sub_checker.sv
// addr_sub_checker: scores a stream of add/subtract results from an external unit.
// Each accepted vector {a,b,cin,sum,carry} is registered, then compared one cycle
// later against a locally computed reference. The run ends after NUM_VEC compares.
// The block keeps pass/fail counters, a sticky error flag and a capture of the
// first failing vector.
module addr_sub_checker #(
   parameter int WIDTH   = 4,
   parameter int NUM_VEC = 17
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               vld_in,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               cin,
   input  logic [WIDTH-1:0]   sum,
   input  logic               carry,
   output logic               rdy,
   output logic               busy,
   output logic               done,
   output logic [7:0]         pass_cnt,
   output logic [7:0]         fail_cnt,
   output logic               err,
   output logic [7:0]         ff_idx,
   output logic [2*WIDTH:0]   ff_vec
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] NUM_VEC_U8 = 8'(NUM_VEC);
   localparam logic [7:0] LAST_IDX   = NUM_VEC_U8 - 8'd1;
   localparam logic [7:0] CNT_MAX    = 8'hFF;

   state_t             state_q, state_d;
   logic [7:0]         acc_cnt_q, acc_cnt_d;

   // Pipeline stage holding the accepted vector until its compare
   logic               pipe_vld_q, pipe_vld_d;
   logic [WIDTH-1:0]   pipe_a_q, pipe_a_d;
   logic [WIDTH-1:0]   pipe_b_q, pipe_b_d;
   logic               pipe_cin_q, pipe_cin_d;
   logic [WIDTH-1:0]   pipe_sum_q, pipe_sum_d;
   logic               pipe_carry_q, pipe_carry_d;
   logic [7:0]         pipe_idx_q, pipe_idx_d;

   // Result registers
   logic [7:0]         pass_cnt_q, pass_cnt_d;
   logic [7:0]         fail_cnt_q, fail_cnt_d;
   logic               err_q, err_d;
   logic [7:0]         ff_idx_q, ff_idx_d;
   logic [2*WIDTH:0]   ff_vec_q, ff_vec_d;
   logic               rdy_q, rdy_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     exp_res;
   logic               mismatch;
   logic               accept;

   // Reference result for the registered vector; subtract is a + ~b + 1 so carry=1 means no borrow
   always_comb begin
      if (pipe_cin_q)
         exp_res = {1'b0, pipe_a_q} + {1'b0, ~pipe_b_q} + (WIDTH+1)'(1);
      else
         exp_res = {1'b0, pipe_a_q} + {1'b0, pipe_b_q};
      // Case inequality so that any unknown bit on the observed result counts as a miss
      mismatch = ({pipe_carry_q, pipe_sum_q} !== exp_res);
   end

   // Next-state logic for the FSM, the vector pipeline and the result registers
   always_comb begin
      state_d      = state_q;
      acc_cnt_d    = acc_cnt_q;
      pipe_vld_d   = 1'b0;
      pipe_a_d     = pipe_a_q;
      pipe_b_d     = pipe_b_q;
      pipe_cin_d   = pipe_cin_q;
      pipe_sum_d   = pipe_sum_q;
      pipe_carry_d = pipe_carry_q;
      pipe_idx_d   = pipe_idx_q;
      pass_cnt_d   = pass_cnt_q;
      fail_cnt_d   = fail_cnt_q;
      err_d        = err_q;
      ff_idx_d     = ff_idx_q;
      ff_vec_d     = ff_vec_q;
      accept       = vld_in & rdy_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = RUN;
               acc_cnt_d  = 8'd0;
               pass_cnt_d = 8'd0;
               fail_cnt_d = 8'd0;
               err_d      = 1'b0;
               ff_idx_d   = 8'd0;
               ff_vec_d   = '0;
            end
         end
         RUN: begin
            // start is deliberately not looked at while a run is active
            if (accept) begin
               pipe_vld_d   = 1'b1;
               pipe_a_d     = a;
               pipe_b_d     = b;
               pipe_cin_d   = cin;
               pipe_sum_d   = sum;
               pipe_carry_d = carry;
               pipe_idx_d   = acc_cnt_q;
               acc_cnt_d    = acc_cnt_q + 8'd1;
            end
            if (pipe_vld_q) begin
               if (mismatch) begin
                  if (fail_cnt_q != CNT_MAX)
                     fail_cnt_d = fail_cnt_q + 8'd1;
                  if (!err_q) begin
                     err_d    = 1'b1;
                     ff_idx_d = pipe_idx_q;
                     ff_vec_d = {pipe_a_q, pipe_b_q, pipe_cin_q};
                  end
               end else if (pass_cnt_q != CNT_MAX) begin
                  pass_cnt_d = pass_cnt_q + 8'd1;
               end
               if (pipe_idx_q == LAST_IDX)
                  state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      rdy_d  = (state_d == RUN) && (acc_cnt_d < NUM_VEC_U8);
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // All state, with asynchronous clear that also drops any in-flight vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         acc_cnt_q    <= 8'd0;
         pipe_vld_q   <= 1'b0;
         pipe_a_q     <= '0;
         pipe_b_q     <= '0;
         pipe_cin_q   <= 1'b0;
         pipe_sum_q   <= '0;
         pipe_carry_q <= 1'b0;
         pipe_idx_q   <= 8'd0;
         pass_cnt_q   <= 8'd0;
         fail_cnt_q   <= 8'd0;
         err_q        <= 1'b0;
         ff_idx_q     <= 8'd0;
         ff_vec_q     <= '0;
         rdy_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_cnt_q    <= acc_cnt_d;
         pipe_vld_q   <= pipe_vld_d;
         pipe_a_q     <= pipe_a_d;
         pipe_b_q     <= pipe_b_d;
         pipe_cin_q   <= pipe_cin_d;
         pipe_sum_q   <= pipe_sum_d;
         pipe_carry_q <= pipe_carry_d;
         pipe_idx_q   <= pipe_idx_d;
         pass_cnt_q   <= pass_cnt_d;
         fail_cnt_q   <= fail_cnt_d;
         err_q        <= err_d;
         ff_idx_q     <= ff_idx_d;
         ff_vec_q     <= ff_vec_d;
         rdy_q        <= rdy_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign rdy      = rdy_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;
   assign err      = err_q;
   assign ff_idx   = ff_idx_q;
   assign ff_vec   = ff_vec_q;

endmodule

// File: tb/tb_addr_sub_checker.sv
// Directed bench for addr_sub_checker: inputs change on the falling edge,
// outputs are sampled on the falling edge, one line printed per vector driven.
module tb_addr_sub_checker;
   localparam int W  = 4;
   localparam int NV = 17;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           vld_in = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           cin = 1'b0;
   logic [W-1:0]   sum = '0;
   logic           carry = 1'b0;
   logic           rdy, busy, done, err;
   logic [7:0]     pass_cnt, fail_cnt, ff_idx;
   logic [2*W:0]   ff_vec;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   addr_sub_checker #(.WIDTH(W), .NUM_VEC(NV)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .vld_in(vld_in),
      .a(a), .b(b), .cin(cin), .sum(sum), .carry(carry),
      .rdy(rdy), .busy(busy), .done(done),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err),
      .ff_idx(ff_idx), .ff_vec(ff_vec)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Correct {carry,sum} used only to build stimulus for the long runs
   function automatic logic [W:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
      logic [W:0] r;
      if (!m) r = (W+1)'(x) + (W+1)'(y);
      else    r = {x >= y, W'(x - y)};
      return r;
   endfunction

   task automatic drive_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                            input logic [W-1:0] vs, input logic vcy);
      @(negedge clk);
      a = va; b = vb; cin = vc; sum = vs; carry = vcy; vld_in = 1'b1;
      $display("vec a=%h b=%h cin=%b sum=%h carry=%b rdy=%b", va, vb, vc, vs, vcy, rdy);
   endtask

   task automatic idle_cyc();
      @(negedge clk);
      vld_in = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // n back-to-back vectors; vector bad_c has carry flipped, bad_s has sum flipped
   task automatic run_vecs(input int n, input int bad_c, input int bad_s);
      logic [W-1:0] va, vb;
      logic         vc;
      logic [W:0]   r;
      for (int i = 0; i < n; i++) begin
         va = W'(i);
         vb = W'(3 * i + 1);
         vc = i[0];
         r  = ref_res(va, vb, vc);
         drive_vec(va, vb, vc, r[W-1:0] ^ ((i == bad_s) ? {W{1'b1}} : {W{1'b0}}),
                   r[W] ^ (i == bad_c));
      end
      idle_cyc();
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!done && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " pass_cnt"}, 32'(pass_cnt), 32'd0);
      chk({tag, " fail_cnt"}, 32'(fail_cnt), 32'd0);
      chk({tag, " err"},      32'(err),      32'd0);
      chk({tag, " ff_idx"},   32'(ff_idx),   32'd0);
      chk({tag, " ff_vec"},   32'(ff_vec),   32'd0);
      chk({tag, " busy"},     32'(busy),     32'd0);
      chk({tag, " done"},     32'(done),     32'd0);
      chk({tag, " rdy"},      32'(rdy),      32'd0);
   endtask

   initial begin
      // Power-on reset
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // vld_in in IDLE must be ignored
      vld_in = 1'b1; a = 4'h3; b = 4'h5; sum = 4'h8;
      repeat (3) @(negedge clk);
      vld_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle vld pass_cnt", 32'(pass_cnt), 32'd0);
      chk("idle vld busy",     32'(busy),     32'd0);

      // Run 1: directed vectors, mid-run start, then fill to NUM_VEC
      pulse_start();
      chk("run1 busy", 32'(busy), 32'd1);
      chk("run1 rdy",  32'(rdy),  32'd1);

      drive_vec(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0);   // 3+5=8
      idle_cyc();
      chk("add latency pass_cnt", 32'(pass_cnt), 32'd0);
      @(negedge clk);
      chk("add pass_cnt", 32'(pass_cnt), 32'd1);
      chk("add err",      32'(err),      32'd0);

      drive_vec(4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1);   // 5-3=2, no borrow
      drive_vec(4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0);   // 3-5=-2, borrow
      drive_vec(4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1);   // 15+15=30
      idle_cyc();
      @(negedge clk);
      chk("directed pass_cnt", 32'(pass_cnt), 32'd4);
      chk("directed fail_cnt", 32'(fail_cnt), 32'd0);

      pulse_start();                                        // must be ignored
      @(negedge clk);
      chk("midrun start pass_cnt", 32'(pass_cnt), 32'd4);
      chk("midrun start busy",     32'(busy),     32'd1);

      run_vecs(NV - 4, -1, -1);
      wait_done("run1 done");
      chk("run1 pass_cnt", 32'(pass_cnt), 32'd17);
      chk("run1 fail_cnt", 32'(fail_cnt), 32'd0);
      chk("run1 err",      32'(err),      32'd0);
      chk("run1 busy",     32'(busy),     32'd0);
      chk("run1 rdy",      32'(rdy),      32'd0);

      // Results hold in DONE despite vld_in
      vld_in = 1'b1;
      repeat (3) @(negedge clk);
      vld_in = 1'b0;
      chk("hold pass_cnt", 32'(pass_cnt), 32'd17);
      chk("hold done",     32'(done),     32'd1);

      // Run 2: restart from DONE clears, then error injection
      pulse_start();
      chk("restart pass_cnt", 32'(pass_cnt), 32'd0);
      chk("restart fail_cnt", 32'(fail_cnt), 32'd0);
      chk("restart done",     32'(done),     32'd0);
      chk("restart busy",     32'(busy),     32'd1);
      run_vecs(NV, 4, 9);
      wait_done("run2 done");
      chk("run2 pass_cnt", 32'(pass_cnt), 32'd15);
      chk("run2 fail_cnt", 32'(fail_cnt), 32'd2);
      chk("run2 err",      32'(err),      32'd1);
      chk("run2 ff_idx",   32'(ff_idx),   32'd4);
      chk("run2 ff_vec",   32'(ff_vec),   32'h09A);      // {4'h4, 4'hD, 1'b0}

      // Run 3: reset mid-run after 6 vectors (vector 2 bad)
      pulse_start();
      run_vecs(6, 2, -1);
      chk("prereset err", 32'(err), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post reset busy",     32'(busy),     32'd0);
      chk("post reset pass_cnt", 32'(pass_cnt), 32'd0);

      // Run 4: clean full run after reset
      pulse_start();
      run_vecs(NV, -1, -1);
      wait_done("run4 done");
      chk("run4 pass_cnt", 32'(pass_cnt), 32'd17);
      chk("run4 fail_cnt", 32'(fail_cnt), 32'd0);
      chk("run4 err",      32'(err),      32'd0);
      chk("run4 ff_idx",   32'(ff_idx),   32'd0);
      chk("run4 ff_vec",   32'(ff_vec),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
